keypad_lock_ctrl: RTL and testbench
===================================

# keypad_lock_ctrl

Sequencing controller for the 4x4 keypad decoder: consumes the decoded `tecla_value`/`tecla_valid` stream and runs a digit-code lock on it. It handles entry, compare, unlock, optional code reprogramming, inactivity timeout and retry lockout. It sits directly downstream of `decodificador_de_teclado` and drives the lock actuator and alarm outputs.

## Interface
- `DIGITS`, 4: code length in digits (1..8).
- `DEFAULT_CODE`, 16'h1234: reset code, `DIGITS*4` bits, BCD, most significant digit entered first.
- `TIMEOUT_CYC`, 1000: inactivity cycles before abandoning ENTRY, OPEN or PROG.
- `LOCKOUT_CYC`, 5000: duration of LOCKOUT in cycles.
- `MAX_TRIES`, 3: consecutive failed compares that trigger LOCKOUT.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `key_value` in 4: key code from the decoder.
- `key_valid` in 1: key-held level from the decoder; a key event is its rising edge.
- `unlocked` out 1: high while in OPEN or PROG.
- `alarm` out 1: high while in LOCKOUT.
- `code_ok` out 1: one-cycle pulse on successful compare or successful program.
- `code_err` out 1: one-cycle pulse on failed compare or rejected program.
- `entry_count` out `$clog2(DIGITS+1)`: digits currently buffered.
- `state_o` out 3: current state encoding, for debug.

## Operation
- Key classes: 0x0–0x9 are digits; 0xE `*` clears; 0xF `#` enters; 0xA is program; 0xB–0xD are ignored everywhere.
- A key event is `key_valid`=1 at an edge while the registered previous `key_valid`=0. A held key produces exactly one event.
- Digit buffer: a `DIGITS*4` shift register. A new digit shifts in at the LSB nibble. Digits received while `entry_count`==`DIGITS` are dropped; no overwrite and no count change.
- IDLE:
  - Digit: buffer it, count=1, go to ENTRY.
  - All other keys: ignored.
- ENTRY:
  - Digit: shift in and increment count.
  - `*`: clear the buffer and count, go to IDLE.
  - `#`: go to CHECK.
  - Timeout: clear, go to IDLE.
- CHECK (one cycle; input events are ignored):
  - Match requires count==`DIGITS` and buffer==code. On match: `code_ok`, tries=0, go to OPEN.
  - On mismatch: `code_err` and tries+1. If tries+1==`MAX_TRIES`, go to LOCKOUT; otherwise go to IDLE.
  - The buffer and count are cleared on exit in either case.
- OPEN:
  - `*` or `#`: relock, go to IDLE.
  - 0xA: go to PROG (only with the macro).
  - Digits: ignored.
  - Timeout: go to IDLE.
- PROG: digits buffer as in ENTRY.
  - `#` with count==`DIGITS`: code<=buffer, `code_ok`, go to OPEN.
  - `#` with count<`DIGITS`: `code_err`, code unchanged, go to OPEN.
  - `*`: clear, go to OPEN.
  - Timeout: clear, go to IDLE, code unchanged.
  - The buffer is cleared on every exit.
- LOCKOUT:
  - All key events are ignored.
  - After `LOCKOUT_CYC` cycles: tries=0, go to IDLE.
- The tries counter is not affected by timeouts or `*`.

## Timing
- Reset values:
  - state=IDLE.
  - `unlocked`=0, `alarm`=0, `code_ok`=0, `code_err`=0, `entry_count`=0, `state_o`=IDLE.
  - code=`DEFAULT_CODE`, tries=0, timer=0, previous `key_valid`=0.
- Key event sampled at edge N: the state, buffer and count updates are visible after edge N.
- `#` sampled at edge N: CHECK is active during cycle N..N+1. `code_ok`/`code_err` and the next state are visible after edge N+1. The pulse lasts exactly one cycle.
- Timer behaviour:
  - Reloads to 0 on every key event and on every state change.
  - Increments otherwise and saturates.
  - A timeout fires at the edge where the timer==`TIMEOUT_CYC`-1 in ENTRY, OPEN or PROG.
  - LOCKOUT exits at the edge where the timer==`LOCKOUT_CYC`-1.
- A key event and a timeout at the same edge: the key event wins.
- A `key_valid` rise while in CHECK or LOCKOUT is consumed (edge registered) but has no effect. It does not re-fire later.
- Reset asserted mid-operation returns everything to reset values immediately and asynchronously. A programmed code is lost and reverts to `DEFAULT_CODE`.

## Configuration
- `KEYPAD_LOCK_PROG_EN` defined: PROG state, 0xA handling and the writable code register are compiled in.
- Not defined:
  - 0xA in OPEN is ignored.
  - The code is the constant `DEFAULT_CODE`.
  - PROG is unreachable and its logic is absent.
  - `unlocked` is high only in OPEN.

## Structure
- Package `keypad_pkg` holds:
  - The state enum (IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT; 3 bits).
  - Key constants KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_PROG=4'hA.
- Sub-module `keypad_lock_timer`:
  - Shared up-counter with clear, enable and saturation.
  - Its width covers max(`TIMEOUT_CYC`, `LOCKOUT_CYC`).
  - It serves both the timeout and the lockout compares.

## Test plan
All scenarios use `DIGITS`=4, `DEFAULT_CODE`=16'h1234, `TIMEOUT_CYC`=20, `LOCKOUT_CYC`=30, `MAX_TRIES`=3. Each key press holds `key_valid` for 3 cycles.
- Keys 1,2,3,4,# -> `code_ok` for 1 cycle, `unlocked`=1, `entry_count`=0. Then # -> `unlocked`=0, state IDLE.
- Keys 1,2,3,# -> `code_err`, state IDLE, `unlocked`=0.
- Keys 1,2,3,4,5,# -> 5 dropped, `entry_count` stays 4, `code_ok`.
- Three wrong codes (9,9,9,9,#) -> `alarm`=1 after the third. Correct code during LOCKOUT -> ignored. After 30 cycles -> `alarm`=0, IDLE, tries=0.
- With the macro: unlock, then A,5,6,7,8,# -> `code_ok`, stays OPEN. Relock, then 5,6,7,8,# -> unlocked. 1,2,3,4,# -> `code_err`.
- Keys 1,2 then idle for 20 cycles -> `entry_count`=0, IDLE. Reset pulse mid-entry -> all outputs 0 on the reset edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the keypad code lock.
//   - FSM state encodings (3 bits, legacy-compatible localparams)
//   - Special key codes (*, #, program)
//   - Key classification helper used by the lock controller
package keypad_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_PROG    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_PROG = 4'hA;

  typedef enum logic [2:0] {
    KC_DIGIT = 3'd0,
    KC_STAR  = 3'd1,
    KC_HASH  = 3'd2,
    KC_PROG  = 3'd3,
    KC_NONE  = 3'd4
  } key_class_e;

  // Maps a raw key code onto its role; 0xB..0xD fall into KC_NONE.
  function automatic key_class_e key_class(input logic [3:0] k);
    key_class_e c;
    case (k)
      KEY_STAR: c = KC_STAR;
      KEY_HASH: c = KC_HASH;
      KEY_PROG: c = KC_PROG;
      default:  c = (k <= 4'h9) ? KC_DIGIT : KC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_lock_timer.sv
// keypad_lock_timer: saturating up-counter shared by the inactivity
// timeout and the lockout duration.
//   clk   - clock
//   rst   - asynchronous active-low reset
//   clr   - synchronous clear to zero (wins over en)
//   en    - count enable
//   count - current count, holds at all-ones
module keypad_lock_timer
  import keypad_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next-count selection: clear, saturating increment or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: digit-code lock driven by the keypad decoder stream.
// Handles code entry, compare, unlock, inactivity timeout, retry lockout
// and (optionally) code reprogramming.
// Optional feature macro: KEYPAD_LOCK_PROG_EN (PROG state + writable code).
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   key_value[3:0]    - decoded key code
//   key_valid         - key-held level; rising edge is one key event
//   unlocked          - high in OPEN (and PROG when compiled in)
//   alarm             - high in LOCKOUT
//   code_ok/code_err  - one-cycle result pulses
//   entry_count       - digits currently buffered
//   state_o[2:0]      - current FSM state (debug)
module keypad_lock_ctrl
  import keypad_pkg::*;
#(
  parameter int                  DIGITS       = 4,
  parameter logic [DIGITS*4-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                  TIMEOUT_CYC  = 1000,
  parameter int                  LOCKOUT_CYC  = 5000,
  parameter int                  MAX_TRIES    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   key_value,
  input  logic                         key_valid,
  output logic                         unlocked,
  output logic                         alarm,
  output logic                         code_ok,
  output logic                         code_err,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count,
  output logic [2:0]                   state_o
);

  localparam int BUF_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TMAX  = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [2:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             kv_q;
  logic             code_ok_q, code_ok_d, code_err_q, code_err_d;
  logic             unlocked_q, unlocked_d, alarm_q, alarm_d;

  logic [BUF_W-1:0] code_s;
  logic [BUF_W-1:0] buf_shift_s;
  logic [TMR_W-1:0] timer_s;
  logic             key_evt_s, timeout_s, lock_done_s, buf_full_s, tmr_clr_s;
  key_class_e       kc_s;

  assign key_evt_s   = key_valid & ~kv_q;
  assign kc_s        = key_class(key_value);
  assign buf_full_s  = (count_q == CNT_W'(DIGITS));
  assign buf_shift_s = (buf_q << 3'd4) | BUF_W'(key_value);
  assign timeout_s   = (timer_s == TMR_W'(TIMEOUT_CYC - 1));
  assign lock_done_s = (timer_s == TMR_W'(LOCKOUT_CYC - 1));

  // Key events are deliberately not reloads in LOCKOUT, so pressing keys
  // cannot stretch the lockout window.
  assign tmr_clr_s = (key_evt_s && (state_q != ST_LOCKOUT)) || (state_d != state_q);

  keypad_lock_timer #(.WIDTH(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_s),
    .en    (state_q != ST_IDLE),
    .count (timer_s)
  );

`ifdef KEYPAD_LOCK_PROG_EN
  logic [BUF_W-1:0] code_q, code_d;
  assign code_s = code_q;
`else
  assign code_s = DEFAULT_CODE;
`endif

  // FSM next state, digit buffer, retry counter and result pulses.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    tries_d    = tries_q;
    code_ok_d  = 1'b0;
    code_err_d = 1'b0;
`ifdef KEYPAD_LOCK_PROG_EN
    code_d     = code_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (key_evt_s && (kc_s == KC_DIGIT)) begin
          buf_d   = BUF_W'(key_value);
          count_d = CNT_W'(1'b1);
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (key_evt_s) begin
          case (kc_s)
            KC_DIGIT: begin
              if (!buf_full_s) begin
                buf_d   = buf_shift_s;
                count_d = count_q + CNT_W'(1'b1);
              end else begin
                buf_d   = buf_q;
              end
            end
            KC_STAR: begin
              buf_d   = {BUF_W{1'b0}};
              count_d = {CNT_W{1'b0}};
              state_d = ST_IDLE;
            end
            KC_HASH: state_d = ST_CHECK;
            default: state_d = ST_ENTRY;
          endcase
        end else if (timeout_s) begin
          buf_d   = {BUF_W{1'b0}};
          count_d = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        buf_d   = {BUF_W{1'b0}};
        count_d = {CNT_W{1'b0}};
        if (buf_full_s && (buf_q == code_s)) begin
          code_ok_d = 1'b1;
          tries_d   = {TRY_W{1'b0}};
          state_d   = ST_OPEN;
        end else begin
          code_err_d = 1'b1;
          tries_d    = tries_q + TRY_W'(1'b1);
          if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (key_evt_s && ((kc_s == KC_STAR) || (kc_s == KC_HASH))) begin
          state_d = ST_IDLE;
`ifdef KEYPAD_LOCK_PROG_EN
        end else if (key_evt_s && (kc_s == KC_PROG)) begin
          state_d = ST_PROG;
`endif
        end else if (!key_evt_s && timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OPEN;
        end
      end
`ifdef KEYPAD_LOCK_PROG_EN
      ST_PROG: begin
        if (key_evt_s) begin
          case (kc_s)
            KC_DIGIT: begin
              if (!buf_full_s) begin
                buf_d   = buf_shift_s;
                count_d = count_q + CNT_W'(1'b1);
              end else begin
                buf_d   = buf_q;
              end
            end
            KC_HASH: begin
              if (buf_full_s) begin
                code_d    = buf_q;
                code_ok_d = 1'b1;
              end else begin
                code_err_d = 1'b1;
              end
              buf_d   = {BUF_W{1'b0}};
              count_d = {CNT_W{1'b0}};
              state_d = ST_OPEN;
            end
            KC_STAR: begin
              buf_d   = {BUF_W{1'b0}};
              count_d = {CNT_W{1'b0}};
              state_d = ST_OPEN;
            end
            default: state_d = ST_PROG;
          endcase
        end else if (timeout_s) begin
          buf_d   = {BUF_W{1'b0}};
          count_d = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PROG;
        end
      end
`endif
      ST_LOCKOUT: begin
        if (lock_done_s) begin
          tries_d = {TRY_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: begin
        buf_d   = {BUF_W{1'b0}};
        count_d = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_comb begin
`ifdef KEYPAD_LOCK_PROG_EN
    unlocked_d = (state_d == ST_OPEN) || (state_d == ST_PROG);
`else
    unlocked_d = (state_d == ST_OPEN);
`endif
    alarm_d = (state_d == ST_LOCKOUT);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= {BUF_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      tries_q    <= {TRY_W{1'b0}};
      kv_q       <= 1'b0;
      code_ok_q  <= 1'b0;
      code_err_q <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      tries_q    <= tries_d;
      kv_q       <= key_valid;
      code_ok_q  <= code_ok_d;
      code_err_q <= code_err_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

`ifdef KEYPAD_LOCK_PROG_EN
  // Writable code register; a reset restores the default code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= DEFAULT_CODE;
    end else begin
      code_q <= code_d;
    end
  end
`endif

  assign unlocked    = unlocked_q;
  assign alarm       = alarm_q;
  assign code_ok     = code_ok_q;
  assign code_err    = code_err_q;
  assign entry_count = count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: directed + randomized self-checking bench for
// keypad_lock_ctrl. A queue-based behavioural model predicts every output
// on every cycle; directed steps add scenario-level checks.
module tb_keypad_lock_ctrl;

  localparam int T_TO = 20;
  localparam int T_LK = 30;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_PROG = 4, M_LOCK = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_value = 4'h0;
  logic       key_valid = 1'b0;
  logic       unlocked, alarm, code_ok, code_err;
  logic [2:0] entry_count;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;
  int ok_seen = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  keypad_lock_ctrl #(
    .DIGITS(4), .DEFAULT_CODE(16'h1234), .TIMEOUT_CYC(T_TO),
    .LOCKOUT_CYC(T_LK), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .key_value(key_value), .key_valid(key_valid),
    .unlocked(unlocked), .alarm(alarm), .code_ok(code_ok), .code_err(code_err),
    .entry_count(entry_count), .state_o(state_o)
  );

  // ---------------- behavioural model ----------------
  int m_mode, m_fails, m_cyc, m_mark;
  bit m_prev, m_ok, m_err;
  int m_digs[$];
  int m_code[$];

  function automatic bit m_match();
    if (m_digs.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_digs[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_fails = 0; m_cyc = 0; m_mark = 0;
    m_prev = 1'b0; m_ok = 1'b0; m_err = 1'b0;
    m_digs.delete();
    m_code = '{1, 2, 3, 4};
  endtask

  task automatic model_step(input bit kv, input int v);
    bit evt;
    int nxt, since;
    evt = kv && !m_prev;
    m_prev = kv;
    m_cyc++;
    since = m_cyc - m_mark;
    m_ok = 1'b0; m_err = 1'b0;
    nxt = m_mode;
    case (m_mode)
      M_IDLE: if (evt && v <= 9) begin m_digs = '{v}; nxt = M_ENTRY; end
      M_ENTRY: begin
        if (evt) begin
          if (v <= 9) begin if (m_digs.size() < 4) m_digs.push_back(v); end
          else if (v == 14) begin m_digs.delete(); nxt = M_IDLE; end
          else if (v == 15) nxt = M_CHECK;
        end else if (since == T_TO) begin m_digs.delete(); nxt = M_IDLE; end
      end
      M_CHECK: begin
        if (m_match()) begin m_ok = 1'b1; m_fails = 0; nxt = M_OPEN; end
        else begin m_err = 1'b1; m_fails++; nxt = (m_fails == 3) ? M_LOCK : M_IDLE; end
        m_digs.delete();
      end
      M_OPEN: begin
        if (evt && (v == 14 || v == 15)) nxt = M_IDLE;
`ifdef KEYPAD_LOCK_PROG_EN
        else if (evt && v == 10) nxt = M_PROG;
`endif
        else if (!evt && since == T_TO) nxt = M_IDLE;
      end
      M_PROG: begin
        if (evt) begin
          if (v <= 9) begin if (m_digs.size() < 4) m_digs.push_back(v); end
          else if (v == 15) begin
            if (m_digs.size() == 4) begin m_code = m_digs; m_ok = 1'b1; end
            else m_err = 1'b1;
            m_digs.delete(); nxt = M_OPEN;
          end else if (v == 14) begin m_digs.delete(); nxt = M_OPEN; end
        end else if (since == T_TO) begin m_digs.delete(); nxt = M_IDLE; end
      end
      M_LOCK: if (since == T_LK) begin m_fails = 0; nxt = M_IDLE; end
      default: nxt = M_IDLE;
    endcase
    if (nxt != m_mode || (evt && m_mode != M_LOCK)) m_mark = m_cyc;
    m_mode = nxt;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state_o", 32'(state_o), 32'(m_mode));
    chk("unlocked", 32'(unlocked), 32'(m_mode == M_OPEN || m_mode == M_PROG));
    chk("alarm", 32'(alarm), 32'(m_mode == M_LOCK));
    chk("code_ok", 32'(code_ok), 32'(m_ok));
    chk("code_err", 32'(code_err), 32'(m_err));
    chk("entry_count", 32'(entry_count), 32'(m_digs.size()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(key_valid, int'(key_value));
    #1;
    check_all();
    if (code_ok === 1'b1) ok_seen++;
    if (code_err === 1'b1) err_seen++;
  endtask

  task automatic press(input int v, input int hold = 3, input int gap = 2);
    key_value = v[3:0];
    key_valid = 1'b1;
    repeat (hold) tick();
    key_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic press_code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int cc[$];

    // Reset state
    #2 rst = 1'b0;
    #10;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_ok", 32'(code_ok), 32'd0);
    chk("rst_err", 32'(code_err), 32'd0);
    chk("rst_count", 32'(entry_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (2) tick();

    // Correct code unlocks, # relocks
    ok_seen = 0;
    press_code(1, 2, 3, 4); press(15);
    chk("s1_ok_pulses", 32'(ok_seen), 32'd1);
    chk("s1_unlocked", 32'(unlocked), 32'd1);
    chk("s1_count", 32'(entry_count), 32'd0);
    press(15);
    chk("s1_relock", 32'(unlocked), 32'd0);
    chk("s1_idle", 32'(state_o), 32'd0);

    // Short code is rejected
    err_seen = 0;
    press(1); press(2); press(3); press(15);
    chk("s2_err_pulses", 32'(err_seen), 32'd1);
    chk("s2_idle", 32'(state_o), 32'd0);

    // Fifth digit dropped
    ok_seen = 0;
    press_code(1, 2, 3, 4); press(5);
    chk("s3_count_full", 32'(entry_count), 32'd4);
    press(15);
    chk("s3_ok_pulses", 32'(ok_seen), 32'd1);
    press(14);

    // Three failures lock out; keys ignored during lockout
    for (int k = 0; k < 3; k++) begin press_code(9, 9, 9, 9); press(15); end
    chk("s4_alarm_on", 32'(alarm), 32'd1);
    press_code(1, 2, 3, 4);
    chk("s4_still_alarm", 32'(alarm), 32'd1);
    press(15);
    repeat (T_LK) tick();
    chk("s4_alarm_off", 32'(alarm), 32'd0);
    chk("s4_idle", 32'(state_o), 32'd0);
    ok_seen = 0;
    press_code(1, 2, 3, 4); press(15);
    chk("s4_tries_cleared", 32'(ok_seen), 32'd1);
    press(15);

`ifdef KEYPAD_LOCK_PROG_EN
    // Reprogram the code to 5678
    press_code(1, 2, 3, 4); press(15);
    ok_seen = 0;
    press(10); press_code(5, 6, 7, 8); press(15);
    chk("s5_prog_ok", 32'(ok_seen), 32'd1);
    chk("s5_open", 32'(state_o), 32'd3);
    press(15);
    press_code(5, 6, 7, 8); press(15);
    chk("s5_new_code", 32'(unlocked), 32'd1);
    press(15);
    err_seen = 0;
    press_code(1, 2, 3, 4); press(15);
    chk("s5_old_code", 32'(err_seen), 32'd1);
`endif

    // Inactivity timeout in ENTRY
    press(1); press(2);
    repeat (T_TO) tick();
    chk("s6_timeout_count", 32'(entry_count), 32'd0);
    chk("s6_timeout_idle", 32'(state_o), 32'd0);

    // Asynchronous reset mid-entry
    press(1);
    key_value = 4'd2; key_valid = 1'b1;
    tick();
    chk("s7_pre_count", 32'(entry_count), 32'd2);
    rst = 1'b0;
    #1;
    chk("s7_state", 32'(state_o), 32'd0);
    chk("s7_count", 32'(entry_count), 32'd0);
    chk("s7_unlocked", 32'(unlocked), 32'd0);
    chk("s7_alarm", 32'(alarm), 32'd0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        repeat ($urandom_range(15, 35)) tick();
      end else if (r <= 2) begin
        cc = m_code;
        foreach (cc[j]) press(cc[j], $urandom_range(1, 4), $urandom_range(1, 3));
        press(15, $urandom_range(1, 4), $urandom_range(1, 3));
      end else if (r == 3) begin
        press(10, $urandom_range(1, 4), $urandom_range(1, 3));
      end else begin
        press($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(1, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
